timer_apb_slave: RTL and testbench
==================================

Name: timer_apb_slave

Overview:
- APB3 completer (slave) register front-end of the 8-bit timer IP. It answers the CPU-side APB master's write/read transfers.
- Holds TDR, TCR and TSR and exposes TCNT. Drives the control fields to the timer core and captures the core's overflow/underflow events as sticky status.
- Sits between the system APB bus and the timer counter core.

Parameters:
- WAIT_STATES, 0, extra access-phase cycles inserted before PREADY asserts (0..3)
- TDR_RST, 8'h00, reset value of TDR

Ports:
- pclk  input  1  APB clock; all state updates on rising edge
- presetn  input  1  asynchronous active-low reset
- psel  input  1  APB select
- penable  input  1  APB enable (access phase)
- pwrite  input  1  1 = write, 0 = read
- paddr  input  8  register address
- pwdata  input  8  write data
- prdata  output  8  read data
- pready  output  1  transfer-complete
- pslverr  output  1  transfer error (see Optional Feature)
- tcnt  input  8  current counter value from core
- ovf_set  input  1  one-cycle overflow pulse from core
- udf_set  input  1  one-cycle underflow pulse from core
- tdr  output  8  reload value
- load  output  1  TCR[7]
- up_down  output  1  TCR[5]: 0 = up, 1 = down
- count_en  output  1  TCR[4]
- cks  output  2  TCR[1:0] clock select
- ovf_flag  output  1  TSR[0]
- udf_flag  output  1  TSR[1]

Behaviour:
- Reset (presetn low, asynchronous): FSM goes to IDLE, wait counter 0, TDR = TDR_RST, TCR = 0, TSR = 0. prdata = 0, pready = 0, pslverr = 0. All control outputs are 0.
- FSM states:
  - IDLE -> SETUP when psel & !penable.
  - SETUP -> ACCESS next cycle. The wait counter clears on entry to ACCESS.
  - ACCESS: the wait counter increments each cycle while pready = 0.
  - ACCESS -> SETUP on completion if psel & !penable (back-to-back transfer), otherwise -> IDLE.
  - ACCESS -> IDLE at once if psel drops mid-access; no register update.
  - penable high while in IDLE is ignored; no transfer, pready stays 0.
- pready = (state == ACCESS) & (wait counter == WAIT_STATES), combinational. With WAIT_STATES = 0, PREADY asserts in the first access cycle.
- Address map (addresses not listed are unmapped):
  - 0x00 TDR: RW, all 8 bits.
  - 0x01 TCR: RW. Bits 7, 5, 4, 1, 0 are stored. Bits 6, 3, 2 are reserved: they ignore writes and read 0.
  - 0x02 TSR: bits [1:0] write-1-to-clear; bits [7:2] read 0.
  - 0x03 TCNT: read-only, returns tcnt; writes ignored.
  - Other addresses: reads return 0x00; writes ignored.
- Write commit: on the rising edge where psel & penable & pwrite & pready. The register update is visible on prdata of the next read.
- Read: prdata shows the addressed value while psel & penable & !pwrite & pready. Otherwise prdata = 0x00.
- TSR update, per bit, each cycle:
  - The set pulse (ovf_set / udf_set) sets the bit.
  - A W1C write clears the bit.
  - If set and clear happen in the same cycle, set wins and the bit ends at 1.
- ovf_set and udf_set are sampled every cycle, independent of the APB state.
- Reset asserted mid-transfer aborts it. No partial write lands, and pready drops immediately.

Optional Feature:
- Macro TIMER_APB_PSLVERR_EN.
- Defined: pslverr = pready & (an unmapped address, or a write to 0x03). The write is still ignored.
- Undefined: pslverr is tied to 0.

Test Plan:
- Reset, then read 0x00/0x01/0x02 -> returns 0x00 (TDR_RST), 0x00, 0x00; all control outputs 0.
- Write 0xFF to 0x01, read 0x01 -> 0xB3; load = 1, up_down = 1, count_en = 1, cks = 2'b11.
- Write 0xA5 to 0x00 -> tdr = 0xA5 the cycle after PREADY; read back 0xA5. With WAIT_STATES = 2, PREADY asserts on the 3rd access cycle.
- Pulse ovf_set, read 0x02 -> 0x01. Write 0x01 to 0x02 with an ovf_set pulse in the same cycle -> flag stays 1. Write 0x01 again -> read 0x00.
- Drive tcnt = 0x3C, read 0x03 -> 0x3C. Write 0x55 to 0x03 -> ignored; pslverr = 1 only with TIMER_APB_PSLVERR_EN. Read 0x07 -> 0x00.
- Assert presetn low during the ACCESS phase of a write of 0x12 to 0x00 -> tdr = TDR_RST, pready = 0, FSM in IDLE.

Source files
------------

// File: rtl/timer_apb_slave.sv
// APB3 completer for the 8-bit timer: holds TDR/TCR/TSR, exposes TCNT, latches core events as sticky flags.
// Optional `TIMER_APB_PSLVERR_EN flags unmapped addresses and writes to TCNT on pslverr.
module timer_apb_slave #(
  parameter int         WAIT_STATES = 0,
  parameter logic [7:0] TDR_RST     = 8'h00
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  input  logic [7:0] tcnt,
  input  logic       ovf_set,
  input  logic       udf_set,
  output logic [7:0] tdr,
  output logic       load,
  output logic       up_down,
  output logic       count_en,
  output logic [1:0] cks,
  output logic       ovf_flag,
  output logic       udf_flag
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  localparam logic [1:0] WS       = WAIT_STATES[1:0];
  localparam logic [7:0] TCR_MASK = 8'hB3;

  state_e     state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [7:0] tdr_q, tdr_d;
  logic [7:0] tcr_q, tcr_d;
  logic [1:0] tsr_q, tsr_d;
  logic       wr_en, rd_en;
  logic [7:0] rdata;

  assign pready = (state_q == ACCESS) && (wcnt_q == WS);
  assign wr_en  = psel && penable && pwrite && pready;
  assign rd_en  = psel && penable && !pwrite && pready;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE:  if (psel && !penable) state_d = SETUP;
      SETUP: begin
        state_d = ACCESS;
        wcnt_d  = '0;
      end
      ACCESS: begin
        // Losing psel mid-access abandons the transfer without committing
        if (!psel)       state_d = IDLE;
        else if (pready) state_d = (psel && !penable) ? SETUP : IDLE;
        else             wcnt_d  = wcnt_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tdr_d = tdr_q;
    tcr_d = tcr_q;
    tsr_d = tsr_q;
    if (wr_en) begin
      case (paddr)
        8'h00:   tdr_d = pwdata;
        8'h01:   tcr_d = pwdata & TCR_MASK;
        8'h02:   tsr_d = tsr_q & ~pwdata[1:0];
        default: ;
      endcase
    end
    // Core events override a same-cycle W1C so no event is lost
    tsr_d = tsr_d | {udf_set, ovf_set};
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      tdr_q   <= TDR_RST;
      tcr_q   <= '0;
      tsr_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tdr_q   <= tdr_d;
      tcr_q   <= tcr_d;
      tsr_q   <= tsr_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (paddr)
      8'h00:   rdata = tdr_q;
      8'h01:   rdata = tcr_q;
      8'h02:   rdata = {6'b0, tsr_q};
      8'h03:   rdata = tcnt;
      default: rdata = '0;
    endcase
  end

  assign prdata = rd_en ? rdata : 8'h00;

`ifdef TIMER_APB_PSLVERR_EN
  assign pslverr = pready && ((paddr > 8'h03) || (pwrite && paddr == 8'h03));
`else
  assign pslverr = 1'b0;
`endif

  assign tdr      = tdr_q;
  assign load     = tcr_q[7];
  assign up_down  = tcr_q[5];
  assign count_en = tcr_q[4];
  assign cks      = tcr_q[1:0];
  assign ovf_flag = tsr_q[0];
  assign udf_flag = tsr_q[1];
endmodule

// File: tb/tb_timer_apb_slave.sv
// Directed plus randomized bench for timer_apb_slave against a transaction-level register model.
module tb_timer_apb_slave;
  localparam int         WS      = 2;
  localparam logic [7:0] TDR_RST = 8'h00;

  logic       pclk = 1'b0, presetn = 1'b0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = '0, pwdata = '0, tcnt = '0;
  logic       ovf_set = 1'b0, udf_set = 1'b0;
  logic [7:0] prdata, tdr;
  logic       pready, pslverr, load, up_down, count_en, ovf_flag, udf_flag;
  logic [1:0] cks;

  int n_cmp = 0, n_err = 0;

  // Register model: architectural contents only
  logic [7:0] m_tdr, m_tcr, m_tsr;

  timer_apb_slave #(.WAIT_STATES(WS), .TDR_RST(TDR_RST)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tcnt(tcnt), .ovf_set(ovf_set), .udf_set(udf_set), .tdr(tdr), .load(load),
    .up_down(up_down), .count_en(count_en), .cks(cks), .ovf_flag(ovf_flag), .udf_flag(udf_flag)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return m_tdr;
      8'h01:   return m_tcr;
      8'h02:   return m_tsr;
      8'h03:   return tcnt;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic m_err(input logic wr, input logic [7:0] a);
`ifdef TIMER_APB_PSLVERR_EN
    return (a > 8'h03) || (wr && a == 8'h03);
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [7:0] d, input logic [1:0] pulse);
    case (a)
      8'h00: m_tdr = d;
      8'h01: m_tcr = {d[7], 1'b0, d[5], d[4], 2'b00, d[1], d[0]};
      8'h02: m_tsr = m_tsr & ~{6'b0, d[1:0]};
      default: ;
    endcase
    m_tsr = m_tsr | {6'b0, pulse};
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".tdr"}, tdr, m_tdr);
    chk({tag, ".tcr"}, {load, up_down, count_en, cks}, {m_tcr[7], m_tcr[5], m_tcr[4], m_tcr[1:0]});
    chk({tag, ".tsr"}, {udf_flag, ovf_flag}, m_tsr[1:0]);
  endtask

  // Full transfer; pulse is driven as {udf,ovf} on the completing edge. Checks data, error, latency.
  task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic [1:0] pulse,
                     input string tag);
    int cyc;
    logic [7:0] rd;
    logic       er;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    step();
    penable = 1'b1;
    cyc = 1;
    while (!pready && cyc < 20) begin
      step();
      cyc++;
    end
    if (!pready) begin
      n_cmp++; n_err++;
      $error("FAIL %s.timeout observed=%0d expected=%0d", tag, cyc, WS + 2);
    end else begin
      rd = prdata;
      er = pslverr;
      chk({tag, ".lat"}, cyc, WS + 2);
      chk({tag, ".err"}, er, m_err(wr, a));
      if (!wr) chk({tag, ".rd"}, rd, m_read(a));
      else     chk({tag, ".rd0"}, rd, 8'h00);
    end
    {udf_set, ovf_set} = pulse;
    step();
    {udf_set, ovf_set} = 2'b00;
    psel = 1'b0; penable = 1'b0;
    if (wr) m_write(a, d, pulse);
    else    m_tsr = m_tsr | {6'b0, pulse};
    chk_outs(tag);
  endtask

  task automatic pulse_ev(input logic [1:0] p);
    {udf_set, ovf_set} = p;
    step();
    {udf_set, ovf_set} = 2'b00;
    m_tsr = m_tsr | {6'b0, p};
  endtask

  task automatic m_reset();
    m_tdr = TDR_RST; m_tcr = 8'h00; m_tsr = 8'h00;
  endtask

  initial begin
    m_reset();
    repeat (3) step();
    chk("rst.prdata", prdata, 8'h00);
    chk("rst.pready", pready, 1'b0);
    chk("rst.pslverr", pslverr, 1'b0);
    chk_outs("rst");
    presetn = 1'b1;
    step();

    apb(1'b0, 8'h00, 8'h00, 2'b00, "rd_tdr_rst");
    apb(1'b0, 8'h01, 8'h00, 2'b00, "rd_tcr_rst");
    apb(1'b0, 8'h02, 8'h00, 2'b00, "rd_tsr_rst");

    apb(1'b1, 8'h01, 8'hFF, 2'b00, "wr_tcr_ff");
    chk("tcr_fields", {load, up_down, count_en, cks}, 5'b11111);
    apb(1'b0, 8'h01, 8'h00, 2'b00, "rd_tcr_b3");
    apb(1'b1, 8'h01, 8'h00, 2'b00, "wr_tcr_00");

    apb(1'b1, 8'h00, 8'hA5, 2'b00, "wr_tdr_a5");
    chk("tdr_a5", tdr, 8'hA5);
    apb(1'b0, 8'h00, 8'h00, 2'b00, "rd_tdr_a5");

    pulse_ev(2'b01);
    apb(1'b0, 8'h02, 8'h00, 2'b00, "rd_tsr_ovf");
    apb(1'b1, 8'h02, 8'h01, 2'b01, "w1c_vs_set");
    chk("ovf_set_wins", ovf_flag, 1'b1);
    apb(1'b1, 8'h02, 8'h01, 2'b00, "w1c_ovf");
    apb(1'b0, 8'h02, 8'h00, 2'b00, "rd_tsr_clr");
    pulse_ev(2'b10);
    apb(1'b0, 8'h02, 8'h00, 2'b00, "rd_tsr_udf");
    apb(1'b1, 8'h02, 8'h03, 2'b00, "w1c_both");

    tcnt = 8'h3C;
    apb(1'b0, 8'h03, 8'h00, 2'b00, "rd_tcnt");
    apb(1'b1, 8'h03, 8'h55, 2'b00, "wr_tcnt_ro");
    apb(1'b0, 8'h07, 8'h00, 2'b00, "rd_unmapped");
    apb(1'b1, 8'h09, 8'h66, 2'b00, "wr_unmapped");

    // psel withdrawn before pready: transfer dropped
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h77;
    step();
    penable = 1'b1;
    step();
    chk("abort.pready", pready, 1'b0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) step();
    chk("abort.tdr", tdr, m_tdr);

    // penable without a setup phase is ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h99;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_en.pready", pready, 1'b0);
    end
    psel = 1'b0; penable = 1'b0;
    step();
    apb(1'b0, 8'h00, 8'h00, 2'b00, "idle_en.rd");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, d;
      logic       wr;
      logic [1:0] p;
      a  = 8'($urandom_range(0, 7));
      d  = 8'($urandom);
      wr = 1'($urandom);
      p  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      tcnt = 8'($urandom);
      if ($urandom_range(0, 3) == 0) pulse_ev(2'($urandom));
      apb(wr, a, d, p, "rand");
    end

    // Reset during ACCESS of a write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h12;
    step();
    penable = 1'b1;
    step();
    presetn = 1'b0;
    m_reset();
    #1;
    chk("rst_mid.pready", pready, 1'b0);
    chk("rst_mid.tdr", tdr, TDR_RST);
    chk_outs("rst_mid");
    step();
    psel = 1'b0; penable = 1'b0;
    step();
    presetn = 1'b1;
    step();
    chk("rst_mid.idle", pready, 1'b0);
    apb(1'b0, 8'h00, 8'h00, 2'b00, "rst_mid.rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
